// File: rtl/rx_pkg.sv
// rx_pkg: shared types and constants for the receive sequencer.
//   rx_state_e      : sequencer FSM state encoding (exported on rx_sequencer.state)
//   CAUSE_*         : bit positions within irq_cause
//   DEF_*_WIDTH     : default widths used by rx_sequencer parameters
package rx_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEARCH  = 3'd1,
        LOAD    = 3'd2,
        RECEIVE = 3'd3,
        DONE    = 3'd4
    } rx_state_e;

    localparam int CAUSE_DONE    = 0;
    localparam int CAUSE_TIMEOUT = 1;
    localparam int CAUSE_STALL   = 2;
    localparam int CAUSE_W       = 3;

    localparam int DEF_TIMEOUT_WIDTH = 24;
    localparam int DEF_LENGTH_WIDTH  = 16;
    localparam int DEF_FREQ_WIDTH    = 32;
    localparam int DEF_COUNT_WIDTH   = 16;

endpackage

// File: rtl/rx_down_counter.sv
// rx_down_counter: loadable down counter with zero / one flags.
//   clk, reset  : clock, asynchronous active-high reset
//   load        : load count with load_value (wins over dec)
//   load_value  : value to load
//   dec         : decrement by one (caller gates it off at zero)
//   zero, one   : count == 0 / count == 1
module rx_down_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero,
    output logic             one
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load)
            count_d = load_value;
        else if (dec)
            count_d = count_q - WIDTH'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign zero = (count_q == '0);
    assign one  = (count_q == WIDTH'(1));

endmodule

// File: rtl/rx_sequencer.sv
// rx_sequencer: receive-path controller. Arms the synchronizer search with a
// timeout, loads the detected frequency offset into the correction stage,
// gates cfg_length corrected beats downstream, then raises a sticky irq.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   cfg_enable/abort/timeout/length   control-register inputs
//   det_valid, det_freq         synchronizer detection and frequency estimate
//   beat_valid, beat_ready      monitored handshake of the corrected stream
//   sync_enable                 search enable to the synchronizer
//   freq_load, freq_value       load strobe + captured offset to correction
//   gate                        1 = downstream stream passes
//   irq, irq_cause, irq_clear   sticky interrupt {stall, timeout, done}
//   state, frame_count          FSM state and completed-frame counter
//
// Optional build macro RX_SEQUENCER_STALL_WATCHDOG_EN adds a RECEIVE-state
// watchdog that aborts the frame with cause.stall when no beat arrives for
// cfg_timeout cycles. Without it irq_cause[2] is always 0.
module rx_sequencer
    import rx_pkg::*;
#(
    parameter int TIMEOUT_WIDTH = DEF_TIMEOUT_WIDTH,
    parameter int LENGTH_WIDTH  = DEF_LENGTH_WIDTH,
    parameter int FREQ_WIDTH    = DEF_FREQ_WIDTH,
    parameter int COUNT_WIDTH   = DEF_COUNT_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_enable,
    input  logic                     cfg_abort,
    input  logic [TIMEOUT_WIDTH-1:0] cfg_timeout,
    input  logic [LENGTH_WIDTH-1:0]  cfg_length,
    input  logic                     det_valid,
    input  logic [FREQ_WIDTH-1:0]    det_freq,
    input  logic                     beat_valid,
    input  logic                     beat_ready,
    output logic                     sync_enable,
    output logic                     freq_load,
    output logic [FREQ_WIDTH-1:0]    freq_value,
    output logic                     gate,
    output logic                     irq,
    output logic [CAUSE_W-1:0]       irq_cause,
    input  logic                     irq_clear,
    output logic [2:0]               state,
    output logic [COUNT_WIDTH-1:0]   frame_count
);

    rx_state_e state_q, state_d;

    logic                   sync_enable_q, sync_enable_d;
    logic                   freq_load_q, freq_load_d;
    logic [FREQ_WIDTH-1:0]  freq_value_q, freq_value_d;
    logic                   gate_q, gate_d;
    logic                   irq_q, irq_d;
    logic [CAUSE_W-1:0]     irq_cause_q, irq_cause_d;
    logic [COUNT_WIDTH-1:0] frame_count_q, frame_count_d;

    logic               hs;
    logic               tmr_load, tmr_dec, tmr_zero, tmr_one;
    logic               len_load, len_dec, len_zero, len_one;
    logic               freq_cap, frame_inc, stall_hit;
    logic [CAUSE_W-1:0] cause_set;

    assign hs = beat_valid & beat_ready;

    // Search timer: loaded on every entry to SEARCH, counts down to 0 and stops.
    assign tmr_dec = (state_q == SEARCH) && !tmr_zero;

    rx_down_counter #(.WIDTH(TIMEOUT_WIDTH)) u_timer (
        .clk(clk), .reset(reset), .load(tmr_load), .load_value(cfg_timeout),
        .dec(tmr_dec), .zero(tmr_zero), .one(tmr_one)
    );

    assign len_load = (state_q == LOAD);
    assign len_dec  = (state_q == RECEIVE) && hs && !len_zero;

    rx_down_counter #(.WIDTH(LENGTH_WIDTH)) u_length (
        .clk(clk), .reset(reset), .load(len_load), .load_value(cfg_length),
        .dec(len_dec), .zero(len_zero), .one(len_one)
    );

`ifdef RX_SEQUENCER_STALL_WATCHDOG_EN
    logic wd_load, wd_dec, wd_zero, wd_one;

    // Reloaded on RECEIVE entry (from LOAD) and on every beat.
    assign wd_load   = (state_q == LOAD) || ((state_q == RECEIVE) && hs);
    assign wd_dec    = (state_q == RECEIVE) && !wd_zero;
    assign stall_hit = (state_q == RECEIVE) && wd_one && !hs;

    rx_down_counter #(.WIDTH(TIMEOUT_WIDTH)) u_watchdog (
        .clk(clk), .reset(reset), .load(wd_load), .load_value(cfg_timeout),
        .dec(wd_dec), .zero(wd_zero), .one(wd_one)
    );
`else
    assign stall_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        tmr_load  = 1'b0;
        freq_cap  = 1'b0;
        frame_inc = 1'b0;
        cause_set = '0;
        case (state_q)
            IDLE: begin
                if (cfg_enable) begin
                    state_d  = SEARCH;
                    tmr_load = 1'b1;
                end
            end
            SEARCH: begin
                // Detection beats an expiry in the same cycle. A zero timeout
                // never reaches one, so it searches forever.
                if (det_valid) begin
                    state_d  = LOAD;
                    freq_cap = 1'b1;
                end else if (tmr_one) begin
                    state_d                  = IDLE;
                    cause_set[CAUSE_TIMEOUT] = 1'b1;
                end else if (!cfg_enable) begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                state_d = (cfg_length == '0) ? DONE : RECEIVE;
            end
            RECEIVE: begin
                if (hs && len_one) begin
                    state_d = DONE;
                end else if (stall_hit) begin
                    state_d                = IDLE;
                    cause_set[CAUSE_STALL] = 1'b1;
                end
            end
            DONE: begin
                cause_set[CAUSE_DONE] = 1'b1;
                frame_inc             = 1'b1;
                if (cfg_enable) begin
                    state_d  = SEARCH;
                    tmr_load = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides everything: no irq, no counter updates.
        if (cfg_abort) begin
            state_d   = IDLE;
            tmr_load  = 1'b0;
            freq_cap  = 1'b0;
            frame_inc = 1'b0;
            cause_set = '0;
        end
    end

    // Outputs are registered decodes of the next state so they line up with state.
    always_comb begin
        sync_enable_d = (state_d == SEARCH);
        freq_load_d   = (state_d == LOAD);
        gate_d        = (state_d == RECEIVE);
        freq_value_d  = freq_cap ? det_freq : freq_value_q;
        // A new cause in the same cycle as irq_clear survives the clear.
        irq_cause_d   = irq_clear ? cause_set : (irq_cause_q | cause_set);
        irq_d         = (irq_q && !irq_clear) || (cause_set != '0);
        frame_count_d = frame_count_q + COUNT_WIDTH'(frame_inc);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            sync_enable_q <= 1'b0;
            freq_load_q   <= 1'b0;
            freq_value_q  <= '0;
            gate_q        <= 1'b0;
            irq_q         <= 1'b0;
            irq_cause_q   <= '0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            sync_enable_q <= sync_enable_d;
            freq_load_q   <= freq_load_d;
            freq_value_q  <= freq_value_d;
            gate_q        <= gate_d;
            irq_q         <= irq_d;
            irq_cause_q   <= irq_cause_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign state       = state_q;
    assign sync_enable = sync_enable_q;
    assign freq_load   = freq_load_q;
    assign freq_value  = freq_value_q;
    assign gate        = gate_q;
    assign irq         = irq_q;
    assign irq_cause   = irq_cause_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_rx_sequencer.sv
// tb_rx_sequencer: randomized and directed frames against a transaction-level
// expectation (beats passed, cause bits, frame count, timing of irq).
module tb_rx_sequencer;
    import rx_pkg::*;

    localparam int TW = 24;
    localparam int LW = 16;
    localparam int FW = 32;
    localparam int CW = 16;

    logic          clk, reset;
    logic          cfg_enable, cfg_abort, det_valid, beat_valid, beat_ready, irq_clear;
    logic [TW-1:0] cfg_timeout;
    logic [LW-1:0] cfg_length;
    logic [FW-1:0] det_freq;
    logic          sync_enable, freq_load, gate, irq;
    logic [FW-1:0] freq_value;
    logic [2:0]    irq_cause, state;
    logic [CW-1:0] frame_count;

    rx_sequencer #(.TIMEOUT_WIDTH(TW), .LENGTH_WIDTH(LW), .FREQ_WIDTH(FW), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .cfg_enable(cfg_enable), .cfg_abort(cfg_abort),
        .cfg_timeout(cfg_timeout), .cfg_length(cfg_length), .det_valid(det_valid),
        .det_freq(det_freq), .beat_valid(beat_valid), .beat_ready(beat_ready),
        .sync_enable(sync_enable), .freq_load(freq_load), .freq_value(freq_value),
        .gate(gate), .irq(irq), .irq_cause(irq_cause), .irq_clear(irq_clear),
        .state(state), .frame_count(frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Expected sticky cause bits and completed-frame count.
    logic [2:0]    exp_cause;
    logic [CW-1:0] exp_frames;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic to_idle(input bit clr);
        cfg_enable = 1'b0; det_valid = 1'b0; beat_valid = 1'b0; beat_ready = 1'b0;
        irq_clear = clr;
        tick();
        irq_clear = 1'b0;
        if (clr) exp_cause = 3'b000;
        chk("idle_state", state, IDLE);
        chk("idle_irq", irq, exp_cause != 3'b000);
        chk("idle_cause", irq_cause, exp_cause);
    endtask

    // Enter SEARCH, detect after d cycles, then drive beats until DONE.
    // mode 0: continuous handshakes, 1: random traffic + noise, 2: ready toggling.
    task automatic run_frame(input int t, input int d, input logic [FW-1:0] f,
                             input int len, input int mode, input bit clr_done);
        int hs, loads, cyc;
        logic g, v, r;
        cfg_timeout = TW'(t); cfg_length = LW'(len); cfg_enable = 1'b1;
        tick();
        chk("search_entry", state, SEARCH);
        chk("search_sync_en", sync_enable, 1);
        repeat (d) tick();
        det_valid = 1'b1; det_freq = f;
        tick();
        det_valid = 1'b0;
        chk("load_state", state, LOAD);
        chk("load_strobe", freq_load, 1);
        chk("load_value", freq_value, f);
        chk("load_cause", irq_cause, exp_cause);
        hs = 0; loads = 0; cyc = 0;
        while (state != DONE && cyc < 400) begin
            g = gate;
            if (mode == 1) begin
                v = ($urandom % 4) != 0;
                r = $urandom % 2;
                det_valid = $urandom % 2;
                det_freq  = $urandom;
                if (state == RECEIVE) cfg_length = LW'($urandom);
            end else begin
                v = 1'b1;
                r = (mode == 2) ? cyc[0] : 1'b1;
            end
            beat_valid = v; beat_ready = r;
            tick();
            cyc++;
            if (g && v && r) hs++;
            if (freq_load) loads++;
        end
        beat_valid = 1'b0; beat_ready = 1'b0; det_valid = 1'b0;
        chk("frame_bound", cyc < 400, 1);
        chk("beats_passed", hs, len);
        chk("done_gate", gate, 0);
        chk("no_reload", loads, 0);
        irq_clear = clr_done;
        tick();
        irq_clear = 1'b0;
        exp_cause  = clr_done ? 3'b001 : (exp_cause | 3'b001);
        exp_frames = exp_frames + 1'b1;
        chk("done_irq", irq, 1);
        chk("done_cause", irq_cause, exp_cause);
        chk("frame_count", frame_count, exp_frames);
        chk("back_search", state, SEARCH);
        chk("back_sync_en", sync_enable, 1);
        chk("freq_held", freq_value, f);
    endtask

    // Reach RECEIVE and pass nb beats with continuous handshakes.
    task automatic start_and_pass(input int t, input int len, input int nb);
        int hs, cyc;
        logic g;
        cfg_timeout = TW'(t); cfg_length = LW'(len); cfg_enable = 1'b1;
        tick();
        repeat (2) tick();
        det_valid = 1'b1; det_freq = $urandom;
        tick();
        det_valid = 1'b0;
        hs = 0; cyc = 0;
        while (hs < nb && cyc < 100) begin
            g = gate;
            beat_valid = 1'b1; beat_ready = 1'b1;
            tick();
            cyc++;
            if (g) hs++;
        end
        beat_valid = 1'b0; beat_ready = 1'b0;
        chk("pass_beats", hs, nb);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t, n;
        reset = 1'b1;
        cfg_enable = 1'b0; cfg_abort = 1'b0; cfg_timeout = '0; cfg_length = '0;
        det_valid = 1'b0; det_freq = '0; beat_valid = 1'b0; beat_ready = 1'b0;
        irq_clear = 1'b0;
        exp_cause = 3'b000; exp_frames = '0;
        repeat (3) tick();
        chk("rst_state", state, IDLE);
        chk("rst_sync_en", sync_enable, 0);
        chk("rst_gate", gate, 0);
        chk("rst_freq_load", freq_load, 0);
        chk("rst_freq_value", freq_value, 0);
        chk("rst_irq", irq, 0);
        chk("rst_cause", irq_cause, 0);
        chk("rst_frames", frame_count, 0);
        reset = 1'b0;
        tick();

        // Nominal frame: detect at cycle 20, 8 beats.
        run_frame(100, 20, 32'h0001_2345, 8, 0, 1'b0);
        to_idle(1'b1);

        // Ready toggling, 4 beats.
        run_frame(60, 5, 32'hdead_beef, 4, 2, 1'b0);
        to_idle(1'b1);

        // Timeout with no detection, irq exactly t cycles after SEARCH entry.
        t = 50;
        cfg_timeout = TW'(t); cfg_enable = 1'b1;
        tick();
        chk("to_search", state, SEARCH);
        n = 0;
        while (!irq && n < t + 20) begin tick(); n++; end
        exp_cause = exp_cause | 3'b010;
        chk("to_cycles", n, t);
        chk("to_cause", irq_cause, exp_cause);
        chk("to_state", state, IDLE);
        chk("to_sync_en", sync_enable, 0);
        to_idle(1'b0);
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;
        exp_cause = 3'b000;
        chk("clr_irq", irq, 0);
        chk("clr_cause", irq_cause, 0);

        // Leave a timeout cause pending, then detect on the expiry cycle and
        // clear during DONE: only the done cause must remain.
        cfg_timeout = TW'(20); cfg_enable = 1'b1;
        tick();
        n = 0;
        while (!irq && n < 40) begin tick(); n++; end
        exp_cause = 3'b010;
        to_idle(1'b0);
        run_frame(30, 29, 32'h0bad_cafe, 3, 0, 1'b1);
        to_idle(1'b1);

        // Abort after 2 of 8 beats.
        start_and_pass(100, 8, 2);
        cfg_abort = 1'b1; cfg_enable = 1'b0;
        tick();
        cfg_abort = 1'b0;
        chk("abort_state", state, IDLE);
        chk("abort_gate", gate, 0);
        chk("abort_irq", irq, 0);
        chk("abort_sync_en", sync_enable, 0);
        chk("abort_frames", frame_count, exp_frames);
        tick();
        chk("abort_stays_idle", state, IDLE);

        // Randomized frames.
        for (int i = 0; i < 6; i++) begin
            int rt, rd, rl;
            rt = $urandom_range(20, 80);
            rd = $urandom_range(0, rt - 1);
            rl = $urandom_range(0, 12);
            run_frame(rt, rd, $urandom, rl, 1, 1'($urandom % 2));
            to_idle(1'b1);
        end

        // Beats stop after 3 of 8 with a 10-cycle timeout.
        start_and_pass(10, 8, 3);
`ifdef RX_SEQUENCER_STALL_WATCHDOG_EN
        n = 0;
        while (!irq && n < 40) begin tick(); n++; end
        exp_cause = 3'b100;
        chk("stall_cycles", n, 10);
        chk("stall_cause", irq_cause, exp_cause);
        chk("stall_state", state, IDLE);
        chk("stall_gate", gate, 0);
        to_idle(1'b1);
`else
        repeat (100) tick();
        chk("nowd_gate", gate, 1);
        chk("nowd_state", state, RECEIVE);
        chk("nowd_irq", irq, 0);
        cfg_abort = 1'b1; cfg_enable = 1'b0;
        tick();
        cfg_abort = 1'b0;
        chk("nowd_abort", state, IDLE);
`endif
        chk("final_frames", frame_count, exp_frames);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rx_sequencer.md
Name: rx_sequencer

Overview:
- Controls the receive datapath: synchronization search, then frequency correction, then frame gating.
- Arms the synchronizer search and applies a timeout to it.
- On detection, loads the measured frequency offset into the correction stage, gates a fixed number of corrected samples downstream, then raises a sticky interrupt.
- Sits between the AXI-Lite control registers and the synchronization / frequency-correction pipeline, in the `clk` domain.

Parameters:
- TIMEOUT_WIDTH, 24, width of the search-timeout and stall-watchdog counters.
- LENGTH_WIDTH, 16, width of the frame-length counter.
- FREQ_WIDTH, 32, width of the frequency-offset word.
- COUNT_WIDTH, 16, width of the completed-frame counter.

Ports:
- clk  in  1  datapath clock
- reset  in  1  asynchronous, active-high reset
- cfg_enable  in  1  level; 1 = run the receiver
- cfg_abort  in  1  pulse; forces return to IDLE
- cfg_timeout  in  TIMEOUT_WIDTH  search timeout in cycles; 0 = infinite
- cfg_length  in  LENGTH_WIDTH  number of samples to pass per frame
- det_valid  in  1  synchronizer detect pulse
- det_freq  in  FREQ_WIDTH  frequency estimate, qualified by det_valid
- beat_valid  in  1  monitored valid of the corrected stream
- beat_ready  in  1  monitored ready of the corrected stream
- sync_enable  out  1  enables the synchronizer search
- freq_load  out  1  one-cycle load strobe to the frequency correction stage
- freq_value  out  FREQ_WIDTH  captured offset; held until the next load
- gate  out  1  1 = downstream stream passes
- irq  out  1  sticky interrupt
- irq_cause  out  3  {stall, timeout, done}, sticky
- irq_clear  in  1  pulse; clears irq and irq_cause
- state  out  3  current FSM state, encoded per rx_pkg
- frame_count  out  COUNT_WIDTH  completed frames; wraps modulo 2^COUNT_WIDTH

Behaviour:
- Reset: all outputs 0; state = IDLE.
- All outputs are registered; every transition below takes effect on the next clock edge.
- IDLE:
  - If cfg_enable = 1: load the timer with cfg_timeout and go to SEARCH.
- SEARCH:
  - sync_enable = 1. The timer decrements each cycle when nonzero.
  - det_valid = 1: capture det_freq, go to LOAD. Detection wins over expiry in the same cycle.
  - Timer reaches 1 → 0 without detection (cfg_timeout ≠ 0): set irq and cause.timeout, go to IDLE.
  - cfg_enable = 0: go to IDLE with no irq.
- LOAD:
  - Exactly one cycle. freq_load = 1; freq_value updates in the same cycle.
  - Load the length counter with cfg_length.
  - Go to RECEIVE, or directly to DONE if cfg_length = 0.
- RECEIVE:
  - gate = 1; sync_enable = 0.
  - Each cycle with beat_valid & beat_ready decrements the length counter.
  - A handshake while the counter = 1: go to DONE. gate drops on the following cycle, so exactly cfg_length beats pass.
  - cfg_enable falling does not interrupt the frame.
- DONE:
  - One cycle. Set irq and cause.done; increment frame_count.
  - Go to SEARCH (timer reloaded) if cfg_enable = 1, otherwise IDLE.
- cfg_abort: highest priority, any state → IDLE next cycle. All enables and gate drop; no irq; counters are not updated.
- det_valid outside SEARCH is ignored.
- cfg_* values are sampled only at the load points above. Changes mid-frame take effect on the next frame.
- irq_clear together with a new cause in the same cycle: the set wins, and only the new cause bit remains.

Optional Feature:
- Macro: RX_SEQUENCER_STALL_WATCHDOG_EN.
- With the macro: in RECEIVE, a watchdog is reloaded with cfg_timeout on entry and on every handshake. If it expires (cfg_timeout ≠ 0), set irq and cause.stall, and go to IDLE.
- Without the macro: no watchdog logic; irq_cause[2] tied to 0.

Decomposition:
- rx_pkg holds:
  - state enum IDLE = 0, SEARCH = 1, LOAD = 2, RECEIVE = 3, DONE = 4;
  - cause bit indices CAUSE_DONE = 0, CAUSE_TIMEOUT = 1, CAUSE_STALL = 2;
  - default width localparams.
- One sub-module, rx_down_counter: parameterized width, load/decrement, with `zero` and `one` flags. Instantiated for the search timer, the length counter and, when enabled, the watchdog.

Test Plan:
- cfg_enable = 1, cfg_timeout = 100, det_valid at cycle 20 with det_freq = 0x0001_2345, cfg_length = 8, continuous handshakes → freq_load for 1 cycle with freq_value = 0x0001_2345; gate high for exactly 8 beats; irq = 1, irq_cause = 3'b001, frame_count = 1; back in SEARCH.
- cfg_timeout = 50, no det_valid → irq rises 50 cycles after SEARCH entry, irq_cause = 3'b010, state IDLE; irq_clear → irq = 0, cause = 0.
- cfg_length = 4, beat_ready toggled 1/0 → gate stays high until the 4th handshake; exactly 4 handshakes observed while gate = 1.
- cfg_abort mid-RECEIVE after 2 of 8 beats → IDLE next cycle; gate = 0; irq = 0; frame_count unchanged.
- det_valid on the same cycle the timer expires → LOAD taken, no timeout cause; irq_clear on a DONE cycle → irq stays 1.
- With RX_SEQUENCER_STALL_WATCHDOG_EN, cfg_timeout = 10, beats stop after 3 of 8 → irq, irq_cause = 3'b100 ten cycles after the last beat; without the macro, gate stays high indefinitely.
